// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, decode constants, the issue record
// carried to alu32, and the MIPS-style ALUOp/funct decode helper.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_f_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_f_e      f;
  } issue_t;

  typedef struct packed {
    logic   legal;
    alu_f_e f;
  } decode_t;

  // Illegal encodings return legal = 0 with f forced to AND so nothing is X.
  function automatic decode_t decode_op(input logic [1:0] aluop, input logic [5:0] funct);
    decode_t d;
    d.legal = 1'b1;
    d.f     = ALU_AND;
    case (aluop)
      ALUOP_ADD: d.f = ALU_ADD;
      ALUOP_SUB: d.f = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: d.f = ALU_ADD;
          FUNCT_SUB: d.f = ALU_SUB;
          FUNCT_AND: d.f = ALU_AND;
          FUNCT_OR:  d.f = ALU_OR;
          FUNCT_SLT: d.f = ALU_SLT;
          default:   d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO of issue records. Pointers carry one extra wrap bit so
// full and empty are told apart without an occupancy counter. The head entry
// is read straight from storage and reads as zero whenever the FIFO is empty.
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  issue_t wr_data,
  input  logic   pop,
  output issue_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  issue_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally modulo 2*DEPTH through the extra bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage ahead of alu32: decodes ALUOp/funct into the ALU control code,
// buffers legal operations, and drops and counts illegal ones so that the
// ALU only ever receives its five legal control codes.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [2:0]       out_f,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  decode_t dec;
  issue_t  wr_entry;
  issue_t  head;
  logic    full;
  logic    empty;
  logic    in_fire;
  logic    push;
  logic    illegal_fire;

  assign dec          = decode_op(in_aluop, in_funct);
  assign in_ready     = !full;
  assign in_fire      = in_valid && in_ready;
  assign push         = in_fire && dec.legal;
  assign illegal_fire = in_fire && !dec.legal;
  assign wr_entry     = '{a: in_a, b: in_b, f: dec.f};

  assign out_valid = !empty;
  assign out_a     = head.a;
  assign out_b     = head.b;
  assign out_f     = head.f;

  alu_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Flag each dropped operation for one cycle and count it, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_pulse <= 1'b0;
      illegal_cnt   <= '0;
    end else begin
      illegal_pulse <= illegal_fire;
      if (illegal_fire && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural model records accepted
// operations at each clock edge, and a monitor compares the ALU-side outputs
// and the illegal-op reporting on the falling edge.
module tb_alu_issue;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_aluop = '0;
  logic [5:0]       in_funct = '0;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_a;
  logic [31:0]      out_b;
  logic [2:0]       out_f;
  logic             illegal_pulse;
  logic [CNT_W-1:0] illegal_cnt;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   occ = 0;
  int   exp_cnt = 0;
  bit   exp_pulse = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_issue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_aluop      (in_aluop),
    .in_funct      (in_funct),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_f         (out_f),
    .illegal_pulse (illegal_pulse),
    .illegal_cnt   (illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference decode straight from the opcode table.
  function automatic void refDecode(input int aluop, input int funct, output bit legal, output logic [2:0] f);
    legal = 1'b1;
    f     = 3'd0;
    if (aluop == 0) f = 3'd2;
    else if (aluop == 1) f = 3'd6;
    else if (aluop == 2) begin
      if (funct == 32) f = 3'd2;
      else if (funct == 34) f = 3'd6;
      else if (funct == 36) f = 3'd0;
      else if (funct == 37) f = 3'd1;
      else if (funct == 42) f = 3'd7;
      else legal = 1'b0;
    end else legal = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model of the stage: decides acceptance from occupancy and pushes expectations.
  always @(posedge clk) begin
    bit          fire;
    bit          legal;
    logic [2:0]  f;
    if (rst_n) begin
      fire = in_valid && (occ < DEPTH);
      refDecode(int'(in_aluop), int'(in_funct), legal, f);
      if (out_ready && occ > 0) occ--;
      if (fire && legal) begin
        exp_q.push_back('{a: in_a, b: in_b, f: f});
        occ++;
      end
      exp_pulse = fire && !legal;
      if (fire && !legal && exp_cnt < CNT_MAX) exp_cnt++;
    end
  end

  // Monitor: compares presented outputs with the scoreboard head, pops on transfer.
  always @(negedge clk) begin
    checkOutput("in_ready", {95'd0, in_ready}, {95'd0, occ < DEPTH});
    checkOutput("out_valid", {95'd0, out_valid}, {95'd0, exp_q.size() > 0});
    if (out_valid) begin
      if (exp_q.size() > 0) begin
        checkOutput("out_a", {64'd0, out_a}, {64'd0, exp_q[0].a});
        checkOutput("out_b", {64'd0, out_b}, {64'd0, exp_q[0].b});
        checkOutput("out_f", {93'd0, out_f}, {93'd0, exp_q[0].f});
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      checkOutput("idle_outputs", {29'd0, out_a, out_b, out_f}, 96'd0);
    end
    checkOutput("illegal_pulse", {95'd0, illegal_pulse}, {95'd0, exp_pulse});
    checkOutput("illegal_cnt", {{(96-CNT_W){1'b0}}, illegal_cnt}, 96'(exp_cnt));
  end

  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b, input bit rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_aluop  = op;
    in_funct  = fn;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic randomCycles(input int n);
    logic [5:0] legal_fn [5];
    logic [5:0] fn;
    logic [1:0] op;
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) fn = legal_fn[$urandom_range(0, 4)];
      else fn = 6'($urandom);
      if (op == 2'b11 && $urandom_range(0, 1) == 0) op = 2'b10;
      applyStimulus($urandom_range(0, 9) < 7, op, fn, $urandom, $urandom, $urandom_range(0, 9) < 6);
    end
  endtask

  // Asynchronous reset in mid-cycle; the model forgets everything at the same moment.
  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    exp_q.delete();
    occ       = 0;
    exp_cnt   = 0;
    exp_pulse = 1'b0;
    #1;
    checkOutput("reset_out_valid", {95'd0, out_valid}, 96'd0);
    checkOutput("reset_in_ready", {95'd0, in_ready}, 96'd1);
    checkOutput("reset_cnt", {{(96-CNT_W){1'b0}}, illegal_cnt}, 96'd0);
    checkOutput("reset_outs", {29'd0, out_a, out_b, out_f}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    checkOutput("por_out_valid", {95'd0, out_valid}, 96'd0);
    checkOutput("por_in_ready", {95'd0, in_ready}, 96'd1);
    checkOutput("por_pulse", {95'd0, illegal_pulse}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // AND of two masks, consumer always ready
    applyStimulus(1'b1, 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
    idle(2, 1'b1);

    // back-to-back add, sub, slt
    applyStimulus(1'b1, 2'b00, 6'd0, 32'd1, 32'd2, 1'b1);
    applyStimulus(1'b1, 2'b01, 6'd0, 32'd3, 32'd4, 1'b1);
    applyStimulus(1'b1, 2'b10, 6'b101010, 32'd5, 32'd6, 1'b1);
    idle(2, 1'b1);

    // fill with consumer stalled, third op waits for a pop
    applyStimulus(1'b1, 2'b10, 6'b100000, 32'h11, 32'h12, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'b100101, 32'h21, 32'h22, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'b100010, 32'h31, 32'h32, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'b100010, 32'h31, 32'h32, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'b100010, 32'h31, 32'h32, 1'b1);
    applyStimulus(1'b1, 2'b10, 6'b100010, 32'h31, 32'h32, 1'b1);
    idle(4, 1'b1);

    // illegal encodings, then enough to saturate the counter
    applyStimulus(1'b1, 2'b11, 6'b100000, 32'h41, 32'h42, 1'b1);
    applyStimulus(1'b1, 2'b10, 6'b000000, 32'h51, 32'h52, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < CNT_MAX + 2; i++) applyStimulus(1'b1, 2'b11, 6'($urandom), $urandom, $urandom, 1'b1);
    idle(2, 1'b1);

    // reset with two entries buffered, then single-cycle latency after release
    applyStimulus(1'b1, 2'b00, 6'd0, 32'hA1, 32'hA2, 1'b0);
    applyStimulus(1'b1, 2'b01, 6'd0, 32'hB1, 32'hB2, 1'b0);
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b0);
    asyncReset();
    applyStimulus(1'b1, 2'b10, 6'b100101, 32'hC1, 32'hC2, 1'b1);
    idle(2, 1'b1);

    randomCycles(2500);
    asyncReset();
    randomCycles(1000);
    idle(2 * DEPTH + 2, 1'b1);
    checkOutput("drained", 96'(exp_q.size()), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
